btn_edge_irq_ctrl: RTL

Avalon-MM slave controller for the push-button input port. It synchronises and debounces the raw button lines, detects edges, latches them in a write-1-to-clear edge-capture register, and raises a maskable level interrupt to the Nios II. It replaces the bare read-only button PIO and keeps the same register map, so existing drivers that read address 0 keep working.

---
 rtl/btn_edge_irq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/btn_edge_irq_ctrl.sv
// Push-button Avalon-MM slave: synchronise, debounce, edge-capture (W1C) and maskable level IRQ.
// Optional macro BTN_DEBOUNCE_EN builds the per-bit debounce counters; otherwise stable follows sync.
module btn_edge_irq_ctrl #(
  parameter int   WIDTH      = 2,
  parameter int   DB_CYCLES  = 50000,
  parameter int   EDGE_POL   = 0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (DB_CYCLES < 2 || WIDTH < 1 || WIDTH > 32) begin : g_param_check
    $error("btn_edge_irq_ctrl: WIDTH must be 1..32 and DB_CYCLES at least 2");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {WIDTH{IDLE_LEVEL}};
      r_sync2 <= {WIDTH{IDLE_LEVEL}};
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt [WIDTH];

  // Any sample matching the accepted level restarts the hold count, so bounces never accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_stable <= {WIDTH{IDLE_LEVEL}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stable <= {WIDTH{IDLE_LEVEL}};
    else          r_stable <= r_sync2;
  end
`endif

  assign w_edge = (EDGE_POL != 0) ? (~r_prev & r_stable) : (r_prev & ~r_stable);
  assign w_clr  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_irqmask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_edgecap;
      default: w_rd_mux = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear, so a same-cycle set beats the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= {WIDTH{IDLE_LEVEL}};
      r_edgecap  <= '0;
      r_irqmask  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= r_stable;
      r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
      r_readdata <= w_rd_mux;
      r_irq      <= |(r_edgecap & r_irqmask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
